risk_tile_seq: RTL and testbench
================================

RISK_TILE_SEQ -- requirements
Module: risk_tile_seq

Interface
REQ-001 Parameter LOAD_LAT, default 3: cycles from address presentation to valid load data at the register-file stage.
REQ-002 Parameter NOP_FUNC, default 3'b111: function code driven when no load/store is issued.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_store  input  1  0 = tile load, 1 = tile store.
REQ-008 cmd_reg  input  5  target vector register.
REQ-009 cmd_base  input  17  element address of tile (0,0).
REQ-010 cmd_stride_x / cmd_stride_y  input  15 each  element strides along x / y.
REQ-011 cmd_tiles_x / cmd_tiles_y  input  8 each  tile-grid extent (4x4 elements per tile).
REQ-012 risk_func  output  3  function code to the vector unit.
REQ-013 risk_reg  output  5  register index to the vector unit.
REQ-014 risk_addr  output  17  tile base address to the vector unit.
REQ-015 risk_stride_x / risk_stride_y  output  15 each  strides to the vector unit, held from the accepted command.
REQ-016 busy  output  1  command in progress.
REQ-017 done  output  1  one-cycle pulse at command completion.

Function
REQ-018 The handshake occurs when cmd_valid and cmd_ready are both high on a rising edge; cmd_ready is high only in IDLE.
REQ-019 States are IDLE, RUN, and DRAIN; busy is high in RUN and DRAIN.
REQ-020 IDLE -> RUN on handshake, latching all cmd_* fields.
REQ-021 If cmd_tiles_x or cmd_tiles_y is 0, IDLE -> DRAIN on handshake; no load/store is issued and done pulses in the next cycle.
REQ-022 In RUN, one tile address is issued per cycle in raster order: tx from 0 to tiles_x-1 inner, ty outer.
REQ-023 The tile address is base + 4*tx*stride_x + 4*ty*stride_y, modulo 2^17.
REQ-024 The tile address is formed by accumulation: the row pointer advances by 4*stride_y, and the column pointer resets to the row pointer and advances by 4*stride_x; no multipliers are used.
REQ-025 Store command: risk_func = 3'b001 is presented in the same cycle as its risk_addr.
REQ-026 Load command: risk_func = 3'b000 for a tile is presented exactly LOAD_LAT cycles after that tile's risk_addr, via a LOAD_LAT-deep valid shift register.
REQ-027 Load addresses are pipelined back-to-back, one per cycle.
REQ-028 On any cycle with no issue, risk_func = NOP_FUNC.
REQ-029 risk_addr holds its last value after the final tile address.
REQ-030 RUN -> DRAIN in the cycle after the last tile address is issued.
REQ-031 DRAIN ends when the last func is issued: immediately for stores, or when the load shift register empties.
REQ-032 DRAIN -> IDLE with done = 1 for exactly one cycle.
REQ-033 A new command is accepted no earlier than the cycle after done.
REQ-034 risk_reg = latched cmd_reg throughout the command.
REQ-035 risk_stride_x / risk_stride_y = latched strides throughout the command.
REQ-036 The tile count is tiles_x*tiles_y, up to 65025; the counters are 8-bit.
REQ-037 tx wraps to 0 at tiles_x-1 while ty increments.
REQ-038 cmd_* input changes while busy have no effect.

Reset
REQ-039 resetn low asynchronously forces IDLE and clears the shift register, counters, and pointers.
REQ-040 While resetn is low: cmd_ready = 0, busy = 0, done = 0, risk_func = NOP_FUNC, risk_reg = 0, risk_addr = 0, risk_stride_x = 0, risk_stride_y = 0.
REQ-041 cmd_ready rises in the first cycle after resetn deasserts.
REQ-042 A reset during RUN or DRAIN abandons the command with no further load/store and no done pulse.

Verification
REQ-043 Load: base=0x100, stride_x=1, stride_y=64, tiles 2x2 -> risk_addr 0x100, 0x104, 0x200, 0x204 on consecutive cycles; risk_func=000 on cycles +3..+6 from the first address; done 1 cycle after the last load.
REQ-044 Store: same command with cmd_store=1 -> func 001 coincident with each of the 4 addresses; done 1 cycle after the last store; busy high for 5 cycles.
REQ-045 Wrap: base=0x1FFFC, stride_x=1, tiles 2x1 -> risk_addr 0x1FFFC then 0x00000.
REQ-046 Zero extent: tiles_x=0 -> no func other than NOP; done pulses 1 cycle after handshake; cmd_ready low only for that interval.
REQ-047 Reset in DRAIN: resetn low 1 cycle after the last load address -> no 000 issued, no done, all outputs at reset values, cmd_ready high after release.
REQ-048 Back-to-back: cmd_valid held high with two commands -> the second is accepted in the cycle after the first command's done pulse, with no overlapping funcs.

Source files
------------

// File: rtl/risk_tile_seq_if.sv
// Command and vector-unit bus of the tile load/store sequencer.
// Command handshake: a command transfers on a rising clk edge where cmd_valid
// and cmd_ready are both high; cmd_* must be stable while cmd_valid is high
// and cmd_ready is low, and cmd_ready never depends combinationally on cmd_valid.
interface risk_tile_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_store;
  logic [4:0]  cmd_reg;
  logic [16:0] cmd_base;
  logic [14:0] cmd_stride_x;
  logic [14:0] cmd_stride_y;
  logic [7:0]  cmd_tiles_x;
  logic [7:0]  cmd_tiles_y;

  logic [2:0]  risk_func;
  logic [4:0]  risk_reg;
  logic [16:0] risk_addr;
  logic [14:0] risk_stride_x;
  logic [14:0] risk_stride_y;

  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_store, cmd_reg, cmd_base, cmd_stride_x, cmd_stride_y,
           cmd_tiles_x, cmd_tiles_y,
    output cmd_ready, risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
           busy, done, dbg_state
  );

  // command source / vector-unit observer side
  modport master (
    output cmd_valid, cmd_store, cmd_reg, cmd_base, cmd_stride_x, cmd_stride_y,
           cmd_tiles_x, cmd_tiles_y,
    input  cmd_ready, risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
           busy, done, dbg_state
  );
endinterface

// File: rtl/risk_tile_seq.sv
// Tile load/store sequencer: walks a tiles_x by tiles_y grid of 4x4-element
// tiles in raster order, issuing one tile base address per cycle to the vector
// unit. Stores carry their function code with the address; loads present it
// LOAD_LAT cycles later through a valid shift register.
module risk_tile_seq #(
  parameter int         LOAD_LAT = 3,
  parameter logic [2:0] NOP_FUNC = 3'b111
) (
  input logic      clk,
  input logic      resetn,
  risk_tile_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] FUNC_LOAD  = 3'b000;
  localparam logic [2:0] FUNC_STORE = 3'b001;

  state_t state;
  state_t state_nxt;

  // ready is held low until the first clock after reset release
  logic rdy_q;

  // latched command
  logic        store_q;
  logic [4:0]  reg_q;
  logic [14:0] sx_q;
  logic [14:0] sy_q;
  logic [7:0]  tiles_x_q;
  logic [7:0]  tiles_y_q;

  // tile walk: counters and accumulated pointers (col_ptr is the issued address)
  logic [7:0]  tx_q;
  logic [7:0]  ty_q;
  logic [16:0] row_ptr;
  logic [16:0] col_ptr;
  logic [16:0] step_x;
  logic [16:0] step_y;

  // one bit per in-flight load; MSB marks the cycle its func is presented
  logic [LOAD_LAT-1:0] ld_sr;

  logic hs;
  logic zero_ext;
  logic col_end;
  logic last_tile;
  logic issue;
  logic issue_load;
  logic drain_end;

  assign hs         = bus.cmd_valid && (state == S_IDLE) && rdy_q;
  assign zero_ext   = (bus.cmd_tiles_x == 8'd0) || (bus.cmd_tiles_y == 8'd0);
  assign col_end    = (tx_q == tiles_x_q - 8'd1);
  assign last_tile  = col_end && (ty_q == tiles_y_q - 8'd1);
  assign issue      = (state == S_RUN);
  assign issue_load = issue && !store_q;
  assign drain_end  = (state == S_DRAIN) && (store_q || (ld_sr == '0));
  assign step_x     = {sx_q, 2'b00};
  assign step_y     = {sy_q, 2'b00};

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hs) state_nxt = zero_ext ? S_DRAIN : S_RUN;
      S_RUN:   if (last_tile) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state and the load pipeline
  always_comb begin
    bus.risk_func = NOP_FUNC;
    if (issue && store_q)       bus.risk_func = FUNC_STORE;
    else if (ld_sr[LOAD_LAT-1]) bus.risk_func = FUNC_LOAD;
    bus.cmd_ready = (state == S_IDLE) && rdy_q;
    bus.busy      = (state != S_IDLE);
    bus.done      = drain_end;
    bus.dbg_state = state;
  end

  assign bus.risk_reg      = reg_q;
  assign bus.risk_addr     = col_ptr;
  assign bus.risk_stride_x = sx_q;
  assign bus.risk_stride_y = sy_q;

  // ready enable comes up one clock after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  // command latch and raster walk by pointer accumulation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      store_q   <= 1'b0;
      reg_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      tiles_x_q <= '0;
      tiles_y_q <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      row_ptr   <= '0;
      col_ptr   <= '0;
    end else if (hs) begin
      store_q   <= bus.cmd_store;
      reg_q     <= bus.cmd_reg;
      sx_q      <= bus.cmd_stride_x;
      sy_q      <= bus.cmd_stride_y;
      tiles_x_q <= bus.cmd_tiles_x;
      tiles_y_q <= bus.cmd_tiles_y;
      tx_q      <= '0;
      ty_q      <= '0;
      row_ptr   <= bus.cmd_base;
      col_ptr   <= bus.cmd_base;
    end else if (issue && !last_tile) begin
      if (col_end) begin
        tx_q    <= '0;
        ty_q    <= ty_q + 8'd1;
        row_ptr <= row_ptr + step_y;
        col_ptr <= row_ptr + step_y;
      end else begin
        tx_q    <= tx_q + 8'd1;
        col_ptr <= col_ptr + step_x;
      end
    end
  end

  // load valid pipeline, one entry per issued load address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ld_sr <= '0;
    else         ld_sr <= (ld_sr << 1) | LOAD_LAT'(issue_load);
  end

endmodule

// File: tb/tb_risk_tile_seq.sv
// Bench for risk_tile_seq: reset checks, a table of directed commands,
// hand-written back-to-back and reset-in-drain sequences, and random commands
// checked cycle by cycle against a tile-grid reference model.
module tb_risk_tile_seq;
  localparam int         LOAD_LAT = 3;
  localparam logic [2:0] NOP_FUNC = 3'b111;
  localparam int         MAXC     = 128;

  typedef struct {
    logic        store;
    logic [4:0]  rg;
    logic [16:0] base;
    logic [14:0] sx;
    logic [14:0] sy;
    logic [7:0]  tx;
    logic [7:0]  ty;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          exp_done;
    logic        has_addr;
    logic [16:0] exp_first;
    logic [16:0] exp_last;
  } vec_t;

  logic clk;
  logic resetn;
  risk_tile_seq_if bus();

  risk_tile_seq #(.LOAD_LAT(LOAD_LAT), .NOP_FUNC(NOP_FUNC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state: per-cycle expectations plus ordered func stream
  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  e_func[MAXC];
  logic        e_av[MAXC];
  logic [16:0] e_addr[MAXC];
  logic        e_done[MAXC];
  logic        e_busy[MAXC];
  logic [4:0]  e_reg[MAXC];
  logic [14:0] e_sx[MAXC];
  logic [14:0] e_sy[MAXC];
  vec_t        vecs[8];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, k, act, want);
  endtask

  task automatic clear_exp();
    for (int k = 0; k < MAXC; k++) begin
      e_func[k] = NOP_FUNC;
      e_av[k]   = 1'b0;
      e_addr[k] = '0;
      e_done[k] = 1'b0;
      e_busy[k] = 1'b0;
      e_reg[k]  = '0;
      e_sx[k]   = '0;
      e_sy[k]   = '0;
    end
    exp_q.delete();
  endtask

  // reference model: command accepted on the edge ending cycle s
  task automatic add_cmd(input int s, input cmd_t c, output int d);
    int n;
    int txi;
    int tyi;
    int cy;
    logic [16:0] a;
    n = int'(c.tx) * int'(c.ty);
    a = '0;
    if (n == 0) begin
      d = s + 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        txi = i % int'(c.tx);
        tyi = i / int'(c.tx);
        a = 17'((int'(c.base) + 4 * txi * int'(c.sx) + 4 * tyi * int'(c.sy)) % 131072);
        cy = s + 1 + i;
        e_av[cy]   = 1'b1;
        e_addr[cy] = a;
        if (c.store) e_func[cy] = 3'b001;
        else         e_func[cy + LOAD_LAT] = 3'b000;
        exp_q.push_back(c.store ? 3'b001 : 3'b000);
      end
      d = (c.store ? s + n : s + n + LOAD_LAT) + 1;
      for (int k = s + n + 1; k <= d; k++) begin
        e_av[k]   = 1'b1;
        e_addr[k] = a;
      end
    end
    for (int k = s + 1; k <= d; k++) begin
      e_busy[k] = 1'b1;
      e_reg[k]  = c.rg;
      e_sx[k]   = c.sx;
      e_sy[k]   = c.sy;
    end
    e_done[d] = 1'b1;
  endtask

  task automatic check_cycle(input int k);
    chk("func",  k, 32'(bus.risk_func), 32'(e_func[k]));
    chk("done",  k, 32'(bus.done),      32'(e_done[k]));
    chk("busy",  k, 32'(bus.busy),      32'(e_busy[k]));
    chk("ready", k, 32'(bus.cmd_ready), 32'(!e_busy[k]));
    if (e_av[k]) chk("addr", k, 32'(bus.risk_addr), 32'(e_addr[k]));
    if (e_busy[k]) begin
      chk("reg", k, 32'(bus.risk_reg),      32'(e_reg[k]));
      chk("sx",  k, 32'(bus.risk_stride_x), 32'(e_sx[k]));
      chk("sy",  k, 32'(bus.risk_stride_y), 32'(e_sy[k]));
    end
    if (bus.risk_func != NOP_FUNC) begin
      if (exp_q.size() == 0) chk("extra_func", k, 32'(bus.risk_func), 32'(NOP_FUNC));
      else                   chk("func_seq",   k, 32'(bus.risk_func), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_reset_vals(input int k);
    chk("rst_ready", k, 32'(bus.cmd_ready),     32'd0);
    chk("rst_busy",  k, 32'(bus.busy),          32'd0);
    chk("rst_done",  k, 32'(bus.done),          32'd0);
    chk("rst_func",  k, 32'(bus.risk_func),     32'(NOP_FUNC));
    chk("rst_reg",   k, 32'(bus.risk_reg),      32'd0);
    chk("rst_addr",  k, 32'(bus.risk_addr),     32'd0);
    chk("rst_sx",    k, 32'(bus.risk_stride_x), 32'd0);
    chk("rst_sy",    k, 32'(bus.risk_stride_y), 32'd0);
  endtask

  // driver tasks
  task automatic drive_cmd(input cmd_t c, input logic v);
    bus.cmd_valid    = v;
    bus.cmd_store    = c.store;
    bus.cmd_reg      = c.rg;
    bus.cmd_base     = c.base;
    bus.cmd_stride_x = c.sx;
    bus.cmd_stride_y = c.sy;
    bus.cmd_tiles_x  = c.tx;
    bus.cmd_tiles_y  = c.ty;
  endtask

  task automatic scramble(input logic allow_valid);
    bus.cmd_valid    = allow_valid ? 1'($urandom) : 1'b0;
    bus.cmd_store    = 1'($urandom);
    bus.cmd_reg      = 5'($urandom);
    bus.cmd_base     = 17'($urandom);
    bus.cmd_stride_x = 15'($urandom);
    bus.cmd_stride_y = 15'($urandom);
    bus.cmd_tiles_x  = 8'($urandom);
    bus.cmd_tiles_y  = 8'($urandom);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) chk("ready_wait", w, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input cmd_t c, output int obs_done, output logic [16:0] first,
                         output logic [16:0] last);
    int d;
    obs_done = 0;
    first    = '0;
    last     = '0;
    wait_ready();
    drive_cmd(c, 1'b1);
    clear_exp();
    add_cmd(0, c, d);
    @(negedge clk);
    scramble(d > 1);
    for (int k = 1; k <= d + 1; k++) begin
      check_cycle(k);
      if (k == 1) first = bus.risk_addr;
      if (k == d) last = bus.risk_addr;
      if (bus.done && obs_done == 0) obs_done = k;
      if (k <= d) begin
        @(negedge clk);
        scramble(k + 1 < d);
      end
    end
    chk("q_empty", d + 1, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    cmd_t        c;
    cmd_t        cb;
    int          od;
    int          da;
    int          db;
    logic [16:0] f;
    logic [16:0] l;

    // reset
    scramble(1'b1);
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 check_reset_vals(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0);
    bus.cmd_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 1, 32'(bus.cmd_ready), 32'd1);
    chk("busy_after_rst",  1, 32'(bus.busy),      32'd0);

    // directed table
    vecs[0] = '{c: '{1'b0, 5'd1,  17'h00100, 15'd1,      15'd64, 8'd2, 8'd2}, exp_done: 8, has_addr: 1'b1, exp_first: 17'h00100, exp_last: 17'h00204};
    vecs[1] = '{c: '{1'b1, 5'd2,  17'h00100, 15'd1,      15'd64, 8'd2, 8'd2}, exp_done: 5, has_addr: 1'b1, exp_first: 17'h00100, exp_last: 17'h00204};
    vecs[2] = '{c: '{1'b1, 5'd3,  17'h1FFFC, 15'd1,      15'd0,  8'd2, 8'd1}, exp_done: 3, has_addr: 1'b1, exp_first: 17'h1FFFC, exp_last: 17'h00000};
    vecs[3] = '{c: '{1'b0, 5'd4,  17'h00040, 15'd3,      15'd5,  8'd0, 8'd3}, exp_done: 1, has_addr: 1'b0, exp_first: 17'h0,     exp_last: 17'h0};
    vecs[4] = '{c: '{1'b1, 5'd5,  17'h00040, 15'd3,      15'd5,  8'd4, 8'd0}, exp_done: 1, has_addr: 1'b0, exp_first: 17'h0,     exp_last: 17'h0};
    vecs[5] = '{c: '{1'b0, 5'd6,  17'h00005, 15'd9,      15'd9,  8'd1, 8'd1}, exp_done: 5, has_addr: 1'b1, exp_first: 17'h00005, exp_last: 17'h00005};
    vecs[6] = '{c: '{1'b1, 5'd7,  17'h00000, 15'h7FFF,   15'd0,  8'd3, 8'd1}, exp_done: 4, has_addr: 1'b1, exp_first: 17'h00000, exp_last: 17'h1FFF8};
    vecs[7] = '{c: '{1'b0, 5'd31, 17'h00010, 15'd2,      15'd3,  8'd1, 8'd3}, exp_done: 7, has_addr: 1'b1, exp_first: 17'h00010, exp_last: 17'h00028};
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].c, od, f, l);
      chk("tbl_done", i, 32'(od), 32'(vecs[i].exp_done));
      if (vecs[i].has_addr) begin
        chk("tbl_first", i, 32'(f), 32'(vecs[i].exp_first));
        chk("tbl_last",  i, 32'(l), 32'(vecs[i].exp_last));
      end
    end

    // back-to-back: valid held high across two commands
    c  = '{1'b1, 5'd3, 17'h00040, 15'd5, 15'd0, 8'd2, 8'd1};
    cb = '{1'b0, 5'd9, 17'h00333, 15'd2, 15'd7, 8'd1, 8'd1};
    clear_exp();
    add_cmd(0, c, da);
    add_cmd(da + 1, cb, db);
    wait_ready();
    drive_cmd(c, 1'b1);
    @(negedge clk);
    drive_cmd(cb, 1'b1);
    for (int k = 1; k <= db + 1; k++) begin
      check_cycle(k);
      if (k <= db) begin
        @(negedge clk);
        if (k + 1 == da + 2) bus.cmd_valid = 1'b0;
      end
    end
    chk("b2b_q_empty", db + 1, 32'(exp_q.size()), 32'd0);

    // reset while draining a load
    c = '{1'b0, 5'd12, 17'h00100, 15'd1, 15'd64, 8'd2, 8'd2};
    clear_exp();
    add_cmd(0, c, da);
    wait_ready();
    drive_cmd(c, 1'b1);
    @(negedge clk);
    scramble(1'b0);
    for (int k = 1; k <= 5; k++) begin
      check_cycle(k);
      if (k < 5) @(negedge clk);
    end
    resetn = 1'b0;
    #1 check_reset_vals(5);
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk);
      check_reset_vals(k);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_ready", 9, 32'(bus.cmd_ready), 32'd1);
    chk("rel_busy",  9, 32'(bus.busy),      32'd0);
    for (int k = 9; k <= 12; k++) begin
      chk("rel_func", k, 32'(bus.risk_func), 32'(NOP_FUNC));
      chk("rel_done", k, 32'(bus.done),      32'd0);
      @(negedge clk);
    end

    // random commands against the model
    for (int i = 0; i < 40; i++) begin
      c.store = 1'($urandom);
      c.rg    = 5'($urandom);
      c.base  = 17'($urandom);
      c.sx    = 15'($urandom);
      c.sy    = 15'($urandom);
      c.tx    = 8'($urandom_range(0, 6));
      c.ty    = 8'($urandom_range(0, 6));
      run_cmd(c, od, f, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
